// File: rtl/shape_cmd_scheduler_if.sv
// Requester command/response and shape-processor SFR port bundle
// for the shape command scheduler.
interface shape_cmd_scheduler_if #(
    parameter int NUM_REQ = 4
);
    logic [NUM_REQ-1:0]   req_valid;
    logic [3*NUM_REQ-1:0] req_shape;
    logic [3*NUM_REQ-1:0] req_operation;
    logic [NUM_REQ-1:0]   req_ready;
    logic [NUM_REQ-1:0]   rsp_valid;
    logic                 rsp_accepted;
    logic                 sp_write;
    logic [31:0]          sp_write_data;
    logic                 sp_read;
    logic [31:0]          sp_read_data;

    modport master (
        input  req_valid, req_shape, req_operation, sp_read_data,
        output req_ready, rsp_valid, rsp_accepted,
        output sp_write, sp_write_data, sp_read
    );

    modport slave (
        output req_valid, req_shape, req_operation, sp_read_data,
        input  req_ready, rsp_valid, rsp_accepted,
        input  sp_write, sp_write_data, sp_read
    );
endinterface

// File: rtl/shape_cmd_scheduler.sv
// Round-robin command scheduler owning the shape processor SFR ports.
// Define SHAPE_CMD_SCHED_READBACK_EN to verify each write by read-back.
module shape_cmd_scheduler #(
    parameter int         NUM_REQ   = 4,
    parameter int         SHAPE_LSB = 0,
    parameter int         OP_LSB    = 3,
    parameter logic [2:0] KEEP_CODE = 3'b111
) (
    input logic                    clk,
    input logic                    rst,
    shape_cmd_scheduler_if.master  bus
);
    localparam int PW = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;

`ifdef SHAPE_CMD_SCHED_READBACK_EN
    typedef enum logic [2:0] {
        S_IDLE, S_WRITE, S_READ, S_CHECK, S_RESP
    } state_t;
`else
    typedef enum logic [1:0] {
        S_IDLE, S_WRITE, S_RESP
    } state_t;
`endif

    state_t        state_q, state_d;
    logic [PW-1:0] ptr_q, ptr_d;
    logic [PW-1:0] gnt_q, gnt_d;
    logic [2:0]    shape_q, shape_d;
    logic [2:0]    op_q, op_d;
    logic          acc_q, acc_d;

    logic          any_v;
    logic          hi_found;
    logic [PW-1:0] hi_idx;
    logic [PW-1:0] lo_idx;
    logic [PW-1:0] win_idx;
    logic          unused_rd;

    assign unused_rd = ^bus.sp_read_data;

    // Lowest valid index above the pointer wins, else lowest valid overall.
    always_comb begin
        any_v    = |bus.req_valid;
        hi_found = 1'b0;
        hi_idx   = '0;
        lo_idx   = '0;
        for (int i = NUM_REQ - 1; i >= 0; i--) begin
            if (bus.req_valid[i]) begin
                lo_idx = PW'(i);
                if (PW'(i) > ptr_q) begin
                    hi_found = 1'b1;
                    hi_idx   = PW'(i);
                end
            end
        end
        win_idx = hi_found ? hi_idx : lo_idx;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= S_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            ptr_q   <= PW'(NUM_REQ - 1);
            gnt_q   <= '0;
            shape_q <= '0;
            op_q    <= '0;
            acc_q   <= 1'b0;
        end else begin
            ptr_q   <= ptr_d;
            gnt_q   <= gnt_d;
            shape_q <= shape_d;
            op_q    <= op_d;
            acc_q   <= acc_d;
        end
    end

    always_comb begin
        state_d = state_q;
        ptr_d   = ptr_q;
        gnt_d   = gnt_q;
        shape_d = shape_q;
        op_d    = op_q;
        acc_d   = acc_q;
        unique case (state_q)
            S_IDLE: begin
                if (any_v) begin
                    state_d = S_WRITE;
                    ptr_d   = win_idx;
                    gnt_d   = win_idx;
                    shape_d = bus.req_shape[int'(win_idx)*3 +: 3];
                    op_d    = bus.req_operation[int'(win_idx)*3 +: 3];
                end
            end
`ifdef SHAPE_CMD_SCHED_READBACK_EN
            S_WRITE: state_d = S_READ;
            S_READ:  state_d = S_CHECK;
            S_CHECK: begin
                // KEEP fields are not compared: the processor leaves them as is.
                acc_d = ((shape_q == KEEP_CODE) ||
                         (bus.sp_read_data[SHAPE_LSB +: 3] == shape_q)) &&
                        ((op_q == KEEP_CODE) ||
                         (bus.sp_read_data[OP_LSB +: 3] == op_q));
                state_d = S_RESP;
            end
`else
            S_WRITE: begin
                acc_d   = 1'b1;
                state_d = S_RESP;
            end
`endif
            S_RESP:  state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
    end

    always_comb begin
        bus.req_ready     = '0;
        bus.rsp_valid     = '0;
        bus.rsp_accepted  = 1'b0;
        bus.sp_write      = 1'b0;
        bus.sp_write_data = '0;
        bus.sp_read       = 1'b0;
        unique case (state_q)
            S_IDLE: begin
                if (any_v && !rst) begin
                    bus.req_ready[win_idx] = 1'b1;
                end
            end
            S_WRITE: begin
                bus.sp_write = 1'b1;
                bus.sp_write_data[SHAPE_LSB +: 3] = shape_q;
                bus.sp_write_data[OP_LSB +: 3]    = op_q;
            end
`ifdef SHAPE_CMD_SCHED_READBACK_EN
            S_READ:  bus.sp_read = 1'b1;
            S_CHECK: bus.sp_read = 1'b0;
`endif
            S_RESP: begin
                bus.rsp_valid[gnt_q] = 1'b1;
                bus.rsp_accepted     = acc_q;
            end
            default: bus.sp_write = 1'b0;
        endcase
    end
endmodule

// File: tb/tb_shape_cmd_scheduler.sv
// Scoreboard bench for shape_cmd_scheduler: directed commands, SFR model,
// monitor checking grants, writes, reads and responses.
module tb_shape_cmd_scheduler;
    localparam int N = 4;
`ifdef SHAPE_CMD_SCHED_READBACK_EN
    localparam bit RB  = 1'b1;
    localparam int LAT = 4;
    localparam int GAP = 5;
`else
    localparam bit RB  = 1'b0;
    localparam int LAT = 2;
    localparam int GAP = 3;
`endif

    typedef struct packed {
        logic [1:0] idx;
        logic       acc;
    } rsp_t;

    logic clk = 1'b0;
    logic rst = 1'b1;

    shape_cmd_scheduler_if #(.NUM_REQ(N)) bus ();

    shape_cmd_scheduler #(.NUM_REQ(N)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    always #5 clk = ~clk;

    int          q_gnt[$];
    logic [31:0] q_wd[$];
    rsp_t        q_rsp[$];
    int          n_cmp = 0;
    int          n_bad = 0;
    int          cyc   = 0;
    int          gcyc  = 0;
    logic [31:0] sfr   = 32'h0;
    bit          sfr_ignore = 1'b0;
    logic [2:0]  shp [N];
    logic [2:0]  opc [N];

    always_comb begin
        for (int i = 0; i < N; i++) begin
            bus.req_shape[3*i +: 3]     = shp[i];
            bus.req_operation[3*i +: 3] = opc[i];
        end
        bus.sp_read_data = sfr;
    end

    // SFR model: KEEP fields untouched; ignore mode drops the write.
    always @(posedge clk) begin
        cyc <= cyc + 1;
        if (bus.sp_write && !sfr_ignore) begin
            if (bus.sp_write_data[2:0] != 3'b111) sfr[2:0] <= bus.sp_write_data[2:0];
            if (bus.sp_write_data[5:3] != 3'b111) sfr[5:3] <= bus.sp_write_data[5:3];
        end
    end

    task automatic chk(string name, logic [31:0] act, logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    task automatic fail(string name);
        n_cmp++;
        n_bad++;
        $display("FAIL %s (cycle %0d)", name, cyc);
    endtask

    always @(negedge clk) begin
        int   e;
        rsp_t r;
        if (!rst) begin
            if (bus.req_ready != '0) begin
                if (q_gnt.size() == 0) fail("unexpected_grant");
                else begin
                    e = q_gnt.pop_front();
                    chk("grant", 32'(bus.req_ready), 32'(1) << e);
                end
                gcyc = cyc;
            end
            if (bus.sp_write) begin
                if (q_wd.size() == 0) fail("unexpected_write");
                else chk("wdata", bus.sp_write_data, q_wd.pop_front());
                chk("write_lat", 32'(cyc - gcyc), 32'd1);
                chk("wr_rd_excl", 32'(bus.sp_read), 32'd0);
            end
            if (bus.sp_read) begin
                chk("read_lat", 32'(cyc - gcyc), 32'd2);
            end
            if (bus.rsp_valid != '0) begin
                if (q_rsp.size() == 0) fail("unexpected_rsp");
                else begin
                    r = q_rsp.pop_front();
                    chk("rsp_valid", 32'(bus.rsp_valid), 32'(1) << r.idx);
                    chk("rsp_accepted", 32'(bus.rsp_accepted), 32'(r.acc));
                end
                chk("rsp_lat", 32'(cyc - gcyc), 32'(LAT));
                if (!RB) chk("no_read", 32'(bus.sp_read), 32'd0);
            end
        end
    end

    task automatic exp_cmd(int idx, logic [31:0] wd, logic acc, bit with_rsp);
        rsp_t r;
        q_gnt.push_back(idx);
        q_wd.push_back(wd);
        r.idx = 2'(idx);
        r.acc = acc;
        if (with_rsp) q_rsp.push_back(r);
    endtask

    task automatic run(logic [N-1:0] mask, int n, bit hold);
        int last = 0;
        logic [N-1:0] g;
        bus.req_valid = mask;
        for (int k = 0; k < n; k++) begin
            int t = 0;
            @(negedge clk);
            while (bus.req_ready == '0 && t < 50) begin
                @(negedge clk);
                t++;
            end
            if (t >= 50) begin
                fail("grant_timeout");
                break;
            end
            if (k > 0) chk("grant_gap", 32'(cyc - last), 32'(GAP));
            last = cyc;
            g = bus.req_ready;
            @(posedge clk);
            #1;
            if (!hold) bus.req_valid = bus.req_valid & ~g;
        end
        bus.req_valid = '0;
    endtask

    task automatic drain();
        int t = 0;
        while ((q_gnt.size() + q_wd.size() + q_rsp.size()) != 0 && t < 50) begin
            @(negedge clk);
            t++;
        end
        chk("drain", 32'(q_gnt.size() + q_wd.size() + q_rsp.size()), 32'd0);
        @(posedge clk);
        #1;
    endtask

    task automatic chk_zero(string tag);
        chk({tag, "_req_ready"}, 32'(bus.req_ready), 32'd0);
        chk({tag, "_rsp_valid"}, 32'(bus.rsp_valid), 32'd0);
        chk({tag, "_rsp_acc"}, 32'(bus.rsp_accepted), 32'd0);
        chk({tag, "_sp_write"}, 32'(bus.sp_write), 32'd0);
        chk({tag, "_sp_read"}, 32'(bus.sp_read), 32'd0);
        chk({tag, "_wdata"}, bus.sp_write_data, 32'd0);
    endtask

    task automatic do_reset();
        rst = 1'b1;
        repeat (2) @(posedge clk);
        @(negedge clk);
        chk_zero("reset");
        @(posedge clk);
        #1;
        rst = 1'b0;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog");
        $fatal(1, "watchdog expired");
    end

    initial begin
        int t;
        bus.req_valid = '0;
        for (int i = 0; i < N; i++) begin
            shp[i] = 3'd0;
            opc[i] = 3'd0;
        end
        do_reset();

        // single command from requester 0
        shp[0] = 3'd1; opc[0] = 3'd2;
        exp_cmd(0, 32'h11, 1'b1, 1'b1);
        run(4'b0001, 1, 1'b0);
        drain();

        // all requesters held valid: 0,1,2,3,0
        do_reset();
        for (int i = 0; i < N; i++) begin
            shp[i] = 3'(i);
            opc[i] = 3'(i + 1);
        end
        exp_cmd(0, 32'h08, 1'b1, 1'b1);
        exp_cmd(1, 32'h11, 1'b1, 1'b1);
        exp_cmd(2, 32'h1A, 1'b1, 1'b1);
        exp_cmd(3, 32'h23, 1'b1, 1'b1);
        exp_cmd(0, 32'h08, 1'b1, 1'b1);
        run(4'b1111, 5, 1'b1);
        drain();

        // processor ignores the write
        sfr = 32'h0;
        sfr_ignore = 1'b1;
        shp[2] = 3'd1; opc[2] = 3'd0;
        exp_cmd(2, 32'h01, RB ? 1'b0 : 1'b1, 1'b1);
        run(4'b0100, 1, 1'b0);
        drain();
        sfr_ignore = 1'b0;

        // KEEP shape, op 5
        sfr = 32'h0;
        shp[3] = 3'd7; opc[3] = 3'd5;
        exp_cmd(3, 32'h2F, 1'b1, 1'b1);
        run(4'b1000, 1, 1'b0);
        drain();

        // both fields KEEP
        shp[1] = 3'd7; opc[1] = 3'd7;
        exp_cmd(1, 32'h3F, 1'b1, 1'b1);
        run(4'b0010, 1, 1'b0);
        drain();

        // reset while the command is in flight
        shp[1] = 3'd2; opc[1] = 3'd3;
        exp_cmd(1, 32'h1A, 1'b0, 1'b0);
        run(4'b0010, 1, 1'b0);
        t = 0;
        @(negedge clk);
        while (!(RB ? bus.sp_read : bus.sp_write) && t < 10) begin
            @(negedge clk);
            t++;
        end
        if (t >= 10) fail("abort_wait_timeout");
        #1;
        rst = 1'b1;
        @(posedge clk);
        @(negedge clk);
        chk_zero("abort");
        rst = 1'b0;
        @(posedge clk);
        #1;

        // pointer back at reset: requester 0 beats 2
        shp[0] = 3'd3; opc[0] = 3'd4;
        shp[2] = 3'd5; opc[2] = 3'd6;
        exp_cmd(0, 32'h23, 1'b1, 1'b1);
        exp_cmd(2, 32'h35, 1'b1, 1'b1);
        run(4'b0101, 2, 1'b0);
        drain();

        repeat (3) @(posedge clk);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule

// File: doc/shape_cmd_scheduler.md
# shape_cmd_scheduler

Multi-requester command scheduler in front of the shape processor's control SFR bus. Up to NUM_REQ clients submit {shape, operation} commands; the block grants them round-robin, issues the SFR write, and optionally reads the SFR back to report whether the processor accepted the command. It owns the shape processor's write/read ports. The shape processor silently ignores illegal writes, so the read-back check is the only way clients learn of a rejection.

## Interface
- NUM_REQ, 4, number of requesters (2..8)
- SHAPE_LSB, 0, bit position of the 3-bit SHAPE field in the SFR word
- OP_LSB, 3, bit position of the 3-bit OPERATION field in the SFR word
- KEEP_CODE, 3'b111, field encoding meaning "leave this field unchanged" (KEEP_SHAPE / KEEP_OPERATION)

- clk  in  1  single clock, all logic on posedge
- rst  in  1  synchronous, active-high reset
- req_valid  in  NUM_REQ  per-requester command pending
- req_shape  in  3*NUM_REQ  requested shape, requester i at [3i+2:3i]
- req_operation  in  3*NUM_REQ  requested operation, same packing
- req_ready  out  NUM_REQ  one-hot, one-cycle pulse: command of requester i accepted
- rsp_valid  out  NUM_REQ  one-hot, one-cycle pulse: result for requester i
- rsp_accepted  out  1  qualified by rsp_valid: 1 = SFR holds requested fields
- sp_write  out  1  SFR write strobe
- sp_write_data  out  32  SFR write word; unused bits 0
- sp_read  out  1  SFR read strobe
- sp_read_data  in  32  SFR read word, valid the cycle after sp_read

## Operation
- FSM states: IDLE, WRITE, READ, CHECK, RESP.
- IDLE: if any req_valid, grant by round-robin; pulse req_ready[g]; latch shape/operation of g; go WRITE. Else stay.
- Round-robin: last-grant pointer, reset value NUM_REQ-1 (requester 0 wins first). Winner is the first valid index after the pointer, wrapping. Pointer updates on grant only.
- WRITE: sp_write=1; sp_write_data places latched shape at SHAPE_LSB and operation at OP_LSB. Go READ.
- READ: sp_read=1; go CHECK.
- CHECK: capture sp_read_data. rsp_accepted = AND over the two fields of (latched field == KEEP_CODE or read-back field == latched field). Go RESP.
- RESP: rsp_valid[g]=1 with rsp_accepted; go IDLE.
- A command with both fields KEEP_CODE is still written, and reports accepted=1.
- A write of a value already held in the SFR reports accepted=1. A no-op is indistinguishable from a success, and this is the defined behaviour.
- The requester drops req_valid or presents its next command after its req_ready pulse. req_valid held high is treated as a new command at the next IDLE.
- sp_write and sp_read are never high in the same cycle. Only one command is in flight at a time.

## Timing
- Reset values: req_ready=0, rsp_valid=0, rsp_accepted=0, sp_write=0, sp_read=0, sp_write_data=0, FSM=IDLE, pointer=NUM_REQ-1.
- Grant (req_ready) in cycle T. sp_write in T+1. sp_read in T+2. sp_read_data sampled in T+3. rsp_valid in T+4. Earliest next grant is T+5.
- Throughput: one command per 5 cycles (3 cycles without read-back).
- Requests arriving outside IDLE wait. Requests are never dropped.
- rst asserted in any state: next cycle is IDLE with all outputs at reset values. The in-flight command gets no rsp_valid. A write already issued is not undone.
- Simultaneous requests: exactly one req_ready bit per grant. Starvation bound: any valid requester is granted within NUM_REQ grants.

## Configuration
- SHAPE_CMD_SCHED_READBACK_EN defined: full flow as above.
- Undefined: the READ and CHECK states are removed and sp_read is tied 0. WRITE goes directly to RESP with rsp_accepted=1. Latency from grant to rsp_valid is 2 cycles, and the earliest next grant is T+3.

## Test plan
- Reset, then req_valid=4'b0001, shape=1, op=2 -> req_ready[0] at T; sp_write at T+1 with data 32'h11; rsp_valid[0] at T+4 with rsp_accepted=1 when the SFR reads back 32'h11.
- All four requesters valid continuously -> grant order 0,1,2,3,0 with grants 5 cycles apart; no requester is skipped.
- SFR model ignores the write (read-back keeps shape=0 against requested 1) -> rsp_accepted=0 at T+4.
- Request shape=KEEP_CODE, op=5, read-back op=5 with any shape -> rsp_accepted=1.
- rst pulsed in the READ cycle -> no rsp_valid; all outputs 0 next cycle; the next grant goes to requester 0.
- Macro undefined, single request -> sp_read never asserted; rsp_valid at T+2 with rsp_accepted=1.
